// File: rtl/ac_ctrl_pkg.sv
// Shared types for the AC output-mux control slice: opcode and state encodings,
// the one-hot select vector and its bit positions.
package ac_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_NOT   = 3'd1,
    OP_OR    = 3'd2,
    OP_XOR   = 3'd3,
    OP_SUM   = 3'd4,
    OP_SHIFT = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  typedef logic [5:0] sel_t;

  localparam int unsigned SEL_AND   = 0;
  localparam int unsigned SEL_NOT   = 1;
  localparam int unsigned SEL_OR    = 2;
  localparam int unsigned SEL_XOR   = 3;
  localparam int unsigned SEL_SUM   = 4;
  localparam int unsigned SEL_SHIFT = 5;

  function automatic sel_t onehot(input int unsigned idx);
    return sel_t'(1) << idx;
  endfunction

endpackage

// File: rtl/ac_op_decode.sv
// Combinational opcode -> one-hot mux select decode with illegal-opcode flag.
// AC_OPSEL_ILLEGAL_TRAP_EN: opcodes 6/7 flag illegal with no select; otherwise they decode as AND.
module ac_op_decode
  import ac_ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  output sel_t       sel,
  output logic       illegal
);

  always_comb begin
    sel     = onehot(SEL_AND);
    illegal = 1'b0;
    case (opcode)
      OP_AND:   sel = onehot(SEL_AND);
      OP_NOT:   sel = onehot(SEL_NOT);
      OP_OR:    sel = onehot(SEL_OR);
      OP_XOR:   sel = onehot(SEL_XOR);
      OP_SUM:   sel = onehot(SEL_SUM);
      OP_SHIFT: sel = onehot(SEL_SHIFT);
      default: begin
`ifdef AC_OPSEL_ILLEGAL_TRAP_EN
        sel     = '0;
        illegal = 1'b1;
`else
        sel     = onehot(SEL_AND);
`endif
      end
    endcase
  end

endmodule

// File: rtl/ac_op_sel_ctrl.sv
// Control end of the AC output-mux interface: accepts an opcode, drives registered one-hot
// selects, sequences shifts, waits out settle time and presents res_valid. Macro: AC_OPSEL_ILLEGAL_TRAP_EN.
module ac_op_sel_ctrl
  import ac_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned SHW        = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [2:0]     opcode,
  input  logic [SHW-1:0] shamt,
  output logic           andbit,
  output logic           notbit,
  output logic           orbit,
  output logic           xorbit,
  output logic           sumbit,
  output logic           shiftbit,
  output logic           shift_step,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           err
);

  localparam int unsigned SCW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CW  = (SHW > SCW) ? SHW : SCW;

  state_e        state;
  logic [CW-1:0] cnt;
  sel_t          sel_q;
  sel_t          dec_sel;
  logic          dec_illegal;

  ac_op_decode u_dec (
    .opcode  (opcode),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign op_ready = (state == ST_IDLE);

  assign andbit   = sel_q[SEL_AND];
  assign notbit   = sel_q[SEL_NOT];
  assign orbit    = sel_q[SEL_OR];
  assign xorbit   = sel_q[SEL_XOR];
  assign sumbit   = sel_q[SEL_SUM];
  assign shiftbit = sel_q[SEL_SHIFT];

  // cnt is shared: shift positions remaining in SHIFT, settle cycles remaining in SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel_q      <= '0;
      shift_step <= 1'b0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (dec_illegal) begin
              err <= 1'b1;
            end else begin
              sel_q <= dec_sel;
              if (opcode == OP_SHIFT && shamt != '0) begin
                state      <= ST_SHIFT;
                cnt        <= CW'(shamt);
                shift_step <= 1'b1;
              end else begin
                state <= ST_SETTLE;
                cnt   <= CW'(SETTLE_CYC);
              end
            end
          end
        end
        ST_SHIFT: begin
          if (cnt == CW'(1)) begin
            state      <= ST_SETTLE;
            cnt        <= CW'(SETTLE_CYC);
            shift_step <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == CW'(1)) begin
            state     <= ST_HOLD;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            res_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_op_sel_ctrl.sv
// Directed self-checking bench for ac_op_sel_ctrl (SETTLE_CYC=2, SHW=3).
// Expectations for opcode 7 follow AC_OPSEL_ILLEGAL_TRAP_EN.
module tb_ac_op_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] opcode;
  logic [2:0] shamt;
  logic       andbit, notbit, orbit, xorbit, sumbit, shiftbit;
  logic       shift_step;
  logic       res_valid;
  logic       res_ready;
  logic       err;
  logic [5:0] sel_obs;

  int n_cmp = 0;
  int n_err = 0;

  assign sel_obs = {shiftbit, sumbit, xorbit, orbit, notbit, andbit};

  always #5 clk = ~clk;

  ac_op_sel_ctrl #(.SETTLE_CYC(2), .SHW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .shamt      (shamt),
    .andbit     (andbit),
    .notbit     (notbit),
    .orbit      (orbit),
    .xorbit     (xorbit),
    .sumbit     (sumbit),
    .shiftbit   (shiftbit),
    .shift_step (shift_step),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, 32'(sel_obs), 32'h0);
    check({tag, "_step"}, 32'(shift_step), 32'h0);
    check({tag, "_rvalid"}, 32'(res_valid), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_ready"}, 32'(op_ready), 32'h1);
  endtask

  // Called at a negedge; presents the op so the next posedge is the accept edge (cycle 0)
  // and returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [2:0] sh);
    op_valid = 1'b1;
    opcode   = op;
    shamt    = sh;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
  endtask

  // With res_ready=1: select held cycles 1..lat, shift_step cycles 1..sh,
  // res_valid at lat = 3 + sh, back in IDLE at lat+1.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] sh,
                        input logic [5:0] exp_sel);
    int ns;
    int lat;
    ns  = (op == 3'd5) ? int'(sh) : 0;
    lat = 3 + ns;
    issue(op, sh);
    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      check({tag, "_sel"}, 32'(sel_obs), (c <= lat) ? 32'(exp_sel) : 32'h0);
      check({tag, "_step"}, 32'(shift_step), (c <= ns) ? 32'h1 : 32'h0);
      check({tag, "_rvalid"}, 32'(res_valid), (c == lat) ? 32'h1 : 32'h0);
      check({tag, "_ready"}, 32'(op_ready), (c > lat) ? 32'h1 : 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    opcode    = 3'd0;
    shamt     = 3'd0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset release with no traffic
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("rst");
    end

    // OR: orbit cycles 1-3, res_valid cycle 3, op_ready cycle 4
    run_op("or", 3'd2, 3'd0, 6'b000100);
    run_op("and", 3'd0, 3'd0, 6'b000001);
    run_op("not", 3'd1, 3'd0, 6'b000010);
    run_op("xor", 3'd3, 3'd0, 6'b001000);
    // SHIFT shamt=5: steps cycles 1-5, res_valid cycle 8
    run_op("sh5", 3'd5, 3'd5, 6'b100000);
    // SHIFT shamt=0: no steps, res_valid cycle 3
    run_op("sh0", 3'd5, 3'd0, 6'b100000);
    run_op("sh1", 3'd5, 3'd1, 6'b100000);
    run_op("sh7", 3'd5, 3'd7, 6'b100000);

    // SUM with consumer stalled in HOLD; a new op during the stall is ignored
    res_ready = 1'b0;
    issue(3'd4, 3'd0);
    check("sum_c1_sel", 32'(sel_obs), 32'h10);
    check("sum_c1_rv", 32'(res_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("sum_c3_rv", 32'(res_valid), 32'h1);
    op_valid = 1'b1;
    opcode   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sum_hold_sel", 32'(sel_obs), 32'h10);
      check("sum_hold_rv", 32'(res_valid), 32'h1);
      check("sum_hold_ready", 32'(op_ready), 32'h0);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check_idle("sum_done");
    @(negedge clk);
    check_idle("sum_after");

    // Asynchronous reset in the middle of a shift
    issue(3'd5, 3'd5);
    @(negedge clk);
    check("rstmid_step", 32'(shift_step), 32'h1);
    check("rstmid_sel", 32'(sel_obs), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rstmid_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rstmid_post");
    end

    // Illegal opcode 7
`ifdef AC_OPSEL_ILLEGAL_TRAP_EN
    issue(3'd7, 3'd0);
    check("ill_err", 32'(err), 32'h1);
    check("ill_sel", 32'(sel_obs), 32'h0);
    check("ill_ready", 32'(op_ready), 32'h1);
    check("ill_rv", 32'(res_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("ill_post");
    end
`else
    run_op("op7", 3'd7, 3'd0, 6'b000001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
